// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serialiser (start, 8 data LSB first, optional parity, stop).
// Divider and parity settings are captured when a frame starts and stay fixed until that frame ends.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DIVIDER_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [DIVIDER_WIDTH-1:0]   cycles_per_bit,
  input  logic                       parity_enable,
  input  logic                       parity_odd,
  input  logic [7:0]                 data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic                       tx,
  output logic                       busy,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DW    = DIVIDER_WIDTH;
  localparam logic [CW-1:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // Timer reload value; a divider of zero is treated as one cycle per bit.
  function automatic logic [DW-1:0] period_m1(input logic [DW-1:0] cpb);
    logic [DW-1:0] r;
    if (cpb == {DW{1'b0}}) begin
      r = {DW{1'b0}};
    end else begin
      r = cpb - DW'(1);
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [DW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   cpb_q, cpb_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bit_q, par_bit_d;
  logic            par_en_q, par_en_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;

  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;

  logic            push_s;
  logic            pop_s;
  logic            bit_done_s;
  logic            start_ok_s;
  logic            frame_end_s;
  logic [7:0]      head_s;

  assign head_s = mem_q[rd_ptr_q];

  // Frame sequencer: next state, bit timer, shift register and line level.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cpb_d       = cpb_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    par_en_d    = par_en_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    pop_s       = 1'b0;
    frame_end_s = 1'b0;
    bit_done_s  = (timer_q == {DW{1'b0}});
    start_ok_s  = enable & ~empty_q;

    case (state_q)
      IDLE: begin
        frame_end_s = 1'b1;
      end
      START: begin
        if (bit_done_s) begin
          state_d   = DATA;
          timer_d   = period_m1(cpb_q);
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end else begin
          timer_d = timer_q - DW'(1);
        end
      end
      DATA: begin
        if (bit_done_s) begin
          timer_d = period_m1(cpb_q);
          if (bit_idx_q == 3'd7) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          timer_d = timer_q - DW'(1);
        end
      end
      PARITY: begin
        if (bit_done_s) begin
          state_d = STOP;
          timer_d = period_m1(cpb_q);
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q - DW'(1);
        end
      end
      STOP: begin
        if (bit_done_s) begin
          frame_end_s = 1'b1;
        end else begin
          timer_d = timer_q - DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = {DW{1'b0}};
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A finished stop bit chains straight into the next start bit when data is waiting.
    if (frame_end_s) begin
      if (start_ok_s) begin
        pop_s     = 1'b1;
        state_d   = START;
        cpb_d     = cycles_per_bit;
        par_en_d  = parity_enable;
        par_bit_d = parity_bit(head_s, parity_odd);
        shift_d   = head_s;
        timer_d   = period_m1(cycles_per_bit);
        bit_idx_d = 3'd0;
        tx_d      = 1'b0;
        busy_d    = 1'b1;
      end else begin
        state_d = IDLE;
        timer_d = {DW{1'b0}};
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // FIFO bookkeeping: storage write, pointer wrap and occupancy flags.
  always_comb begin
    push_s   = data_valid & ~full_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_s) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == {CW{1'b0}});
    full_d  = (count_d == FULL_COUNT);
  end

  // State registers; reset forces the line idle and discards queued bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= {DW{1'b0}};
      cpb_q     <= {DW{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cpb_q     <= cpb_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      mem_q     <= mem_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign data_ready = ~full_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shape, parity, FIFO full/back-to-back, divider edges,
// enable drop and asynchronous reset mid-frame.
module tb_uart_tx_fifo;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] cycles_per_bit;
  logic        parity_enable;
  logic        parity_odd;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        tx;
  logic        busy;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.FIFO_DEPTH_LOG2(4), .DIVIDER_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cycles_per_bit(cycles_per_bit),
    .parity_enable(parity_enable), .parity_odd(parity_odd), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .tx(tx), .busy(busy),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    data_valid = 1'b1;
    data_in    = b;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Bounded wait for the start bit; a timeout counts as a failed check.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, tx}, 32'd0);
  endtask

  // Called on the first sample with the start bit on the line; walks every bit cycle.
  task automatic check_frame(input string tag, input logic [7:0] b, input int p,
                             input bit pen, input bit pbit, input bit idle_after);
    logic [10:0] bits;
    int nb;
    bits = '0;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = b[k];
    if (pen) begin
      bits[9]  = pbit;
      bits[10] = 1'b1;
      nb = 11;
    end else begin
      bits[9] = 1'b1;
      nb = 10;
    end
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < p; c++) begin
        chk($sformatf("%s bit%0d cyc%0d", tag, k, c), {31'd0, tx}, {31'd0, bits[k]});
        @(negedge clk);
      end
    end
    if (idle_after) begin
      chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, " tx_idle"}, {31'd0, tx}, 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst            = 1'b0;
    enable         = 1'b0;
    cycles_per_bit = 16'd4;
    parity_enable  = 1'b0;
    parity_odd     = 1'b0;
    data_in        = 8'h00;
    data_valid     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst tx", {31'd0, tx}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst count", {27'd0, fifo_count}, 32'd0);
    chk("rst empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst full", {31'd0, fifo_full}, 32'd0);
    chk("rst ready", {31'd0, data_ready}, 32'd1);
    rst = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // Basic frame 0xA5 with push-to-line latency
    data_valid = 1'b1;
    data_in    = 8'hA5;
    @(negedge clk);
    data_valid = 1'b0;
    chk("lat empty_fall", {31'd0, fifo_empty}, 32'd0);
    chk("lat count1", {27'd0, fifo_count}, 32'd1);
    chk("lat tx_still_high", {31'd0, tx}, 32'd1);
    chk("lat busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("lat busy_high", {31'd0, busy}, 32'd1);
    chk("lat popped", {31'd0, fifo_empty}, 32'd1);
    check_frame("a5", 8'hA5, 4, 1'b0, 1'b0, 1'b1);
    chk("a5 empty_end", {31'd0, fifo_empty}, 32'd1);

    // Parity even then odd
    parity_enable = 1'b1;
    parity_odd    = 1'b0;
    push_byte(8'hA5);
    wait_start("even start");
    check_frame("a5_even", 8'hA5, 4, 1'b1, 1'b0, 1'b1);
    parity_odd = 1'b1;
    push_byte(8'hA5);
    wait_start("odd start");
    check_frame("a5_odd", 8'hA5, 4, 1'b1, 1'b1, 1'b1);
    parity_enable = 1'b0;
    parity_odd    = 1'b0;

    // Fill the FIFO with enable low, then drain back-to-back
    enable         = 1'b0;
    cycles_per_bit = 16'd2;
    data_valid     = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(i);
      @(negedge clk);
    end
    data_in = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    chk("full flag", {31'd0, fifo_full}, 32'd1);
    chk("full count", {27'd0, fifo_count}, 32'd16);
    chk("full ready", {31'd0, data_ready}, 32'd0);
    chk("full tx_idle", {31'd0, tx}, 32'd1);
    enable = 1'b1;
    @(negedge clk);
    chk("drain count15", {27'd0, fifo_count}, 32'd15);
    chk("drain ready", {31'd0, data_ready}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check_frame($sformatf("b2b%0d", i), 8'(i), 2, 1'b0, 1'b0, (i == 15));
    end
    chk("drain count0", {27'd0, fifo_count}, 32'd0);
    chk("drain empty", {31'd0, fifo_empty}, 32'd1);

    // Divider 0 and 1 both give one-cycle bits
    cycles_per_bit = 16'd0;
    push_byte(8'h3C);
    wait_start("div0 start");
    check_frame("div0", 8'h3C, 1, 1'b0, 1'b0, 1'b1);
    cycles_per_bit = 16'd1;
    push_byte(8'hC3);
    wait_start("div1 start");
    check_frame("div1", 8'hC3, 1, 1'b0, 1'b0, 1'b1);

    // Divider change mid-frame applies only to the next frame
    cycles_per_bit = 16'd4;
    data_valid = 1'b1;
    data_in    = 8'h5A;
    @(negedge clk);
    data_in    = 8'h96;
    @(negedge clk);
    data_valid = 1'b0;
    cycles_per_bit = 16'd8;
    chk("div chg count", {27'd0, fifo_count}, 32'd1);
    check_frame("div4", 8'h5A, 4, 1'b0, 1'b0, 1'b0);
    check_frame("div8", 8'h96, 8, 1'b0, 1'b0, 1'b1);

    // Enable dropped during DATA: frame completes, next byte waits
    cycles_per_bit = 16'd4;
    data_valid = 1'b1;
    data_in    = 8'h81;
    @(negedge clk);
    data_in    = 8'h7E;
    @(negedge clk);
    data_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 6) enable = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("en drop frame_len", n, 32'd40);
    chk("en drop tx", {31'd0, tx}, 32'd1);
    chk("en drop count", {27'd0, fifo_count}, 32'd1);
    repeat (20) @(negedge clk);
    chk("en hold busy", {31'd0, busy}, 32'd0);
    chk("en hold count", {27'd0, fifo_count}, 32'd1);
    enable = 1'b1;
    @(negedge clk);
    check_frame("en resume", 8'h7E, 4, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset during DATA
    data_valid = 1'b1;
    data_in    = 8'hF0;
    @(negedge clk);
    data_in    = 8'h0F;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_mid tx_low", {31'd0, tx}, 32'd0);
    chk("rst_mid busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid tx_async", {31'd0, tx}, 32'd1);
    chk("rst_mid count", {27'd0, fifo_count}, 32'd0);
    chk("rst_mid busy_low", {31'd0, busy}, 32'd0);
    chk("rst_mid empty", {31'd0, fifo_empty}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst tx", {31'd0, tx}, 32'd1);
    chk("post_rst busy", {31'd0, busy}, 32'd0);
    chk("post_rst count", {27'd0, fifo_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
